// File: rtl/tdm_slot_tx.sv
// tdm_slot_tx
//   Time-multiplexed transmitter for a shared 16-bit slot bus. A public
//   (L) countdown timer and mode bit alternate L and H slots of SLOT_LEN+1
//   cycles each. The first cycle after a slot boundary (timer==0) is a
//   guard cycle in which nothing is emitted. A one-entry L holding register
//   and a DEPTH-entry H circular queue feed the bus, each only inside its
//   own slot. Slot timing depends only on timer/mode/rst, so H traffic can
//   never influence anything labelled L.
//
// Parameters
//   SLOT_LEN    timer reload value (fits in 16 bits)
//   DEPTH       H queue entries, power of 2, >= 2
// Ports
//   clk, rst    clock and synchronous active-high reset
//   l_in_*      L word valid/ready/data handshake (1-entry holding register)
//   h_in_*      H word valid/ready/data handshake (DEPTH-entry queue)
//   timer       current slot countdown
//   mode        0 = L slot, 1 = H slot
//   data        registered slot bus payload, zero whenever data_valid is low
//   data_valid  payload qualifier
module tdm_slot_tx #(
  parameter int unsigned SLOT_LEN = 10,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        l_in_valid,
  input  logic [15:0] l_in_data,
  output logic        l_in_ready,
  input  logic        h_in_valid,
  input  logic [15:0] h_in_data,
  output logic        h_in_ready,
  output logic [15:0] timer,
  output logic        mode,
  output logic [15:0] data,
  output logic        data_valid
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [15:0]   RELOAD = 16'(SLOT_LEN);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);

  // L-labelled state
  logic [15:0] timer_q, timer_d;
  logic        mode_q, mode_d;
  logic        l_full_q, l_full_d;
  logic [15:0] l_reg_q, l_reg_d;

  // H-labelled state
  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Bus output register (Par mode)
  logic [15:0] data_q, data_d;
  logic        data_valid_q, data_valid_d;

  logic guard;
  logic l_push;
  logic l_emit;
  logic h_push;
  logic h_pop;

  // Next-state logic. Emission decisions use only the current slot state;
  // the L path never looks at any H signal.
  always_comb begin
    timer_d      = timer_q;
    mode_d       = mode_q;
    l_full_d     = l_full_q;
    l_reg_d      = l_reg_q;
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    data_d       = 16'h0000;
    data_valid_d = 1'b0;

    guard  = (timer_q == 16'h0000);
    l_push = l_in_valid && !l_full_q;
    h_push = h_in_valid && (count_q != FULL);
    l_emit = !mode_q && !guard && l_full_q;
    h_pop  = mode_q && !guard && (count_q != '0);

    // Slot schedule: a zero timer reloads and flips the slot type.
    if (guard) begin
      timer_d = RELOAD;
      mode_d  = ~mode_q;
    end else begin
      timer_d = timer_q - 16'h0001;
    end

    // Load only when empty and emit only when full, so the two never overlap.
    if (l_emit) begin
      data_d       = l_reg_q;
      data_valid_d = 1'b1;
      l_full_d     = 1'b0;
    end else if (h_pop) begin
      data_d       = mem_q[rd_ptr_q];
      data_valid_d = 1'b1;
      rd_ptr_d     = rd_ptr_q + PW'(1);
    end

    if (l_push) begin
      l_full_d = 1'b1;
      l_reg_d  = l_in_data;
    end

    if (h_push) begin
      mem_d[wr_ptr_q] = h_in_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({h_push, h_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and output registers; reset discards held and queued words.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q      <= RELOAD;
      mode_q       <= 1'b0;
      l_full_q     <= 1'b0;
      l_reg_q      <= 16'h0000;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      data_q       <= 16'h0000;
      data_valid_q <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      mode_q       <= mode_d;
      l_full_q     <= l_full_d;
      l_reg_q      <= l_reg_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Queue storage needs no reset: entries are only read when count says so.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign timer      = timer_q;
  assign mode       = mode_q;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign l_in_ready = ~l_full_q;
  assign h_in_ready = (count_q != FULL);

endmodule

// File: tb/tb_tdm_slot_tx.sv
// tb_tdm_slot_tx
//   Self-checking bench for tdm_slot_tx. A behavioural model derives the slot
//   schedule arithmetically from the cycle count since reset, keeps the L word
//   as a flag plus value and the H words in a queue, and predicts every
//   registered output after each clock edge. Directed scenarios are followed
//   by randomized traffic and an L-trace comparison with and without H traffic.
module tb_tdm_slot_tx;

  localparam int SLOT_LEN = 10;
  localparam int DEPTH    = 4;

  logic        clk;
  logic        rst;
  logic        l_in_valid;
  logic [15:0] l_in_data;
  logic        l_in_ready;
  logic        h_in_valid;
  logic [15:0] h_in_data;
  logic        h_in_ready;
  logic [15:0] timer;
  logic        mode;
  logic [15:0] data;
  logic        data_valid;

  tdm_slot_tx #(.SLOT_LEN(SLOT_LEN), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .l_in_valid (l_in_valid),
    .l_in_data  (l_in_data),
    .l_in_ready (l_in_ready),
    .h_in_valid (h_in_valid),
    .h_in_data  (h_in_data),
    .h_in_ready (h_in_ready),
    .timer      (timer),
    .mode       (mode),
    .data       (data),
    .data_valid (data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          k = 0;
  bit          m_lfull = 0;
  logic [15:0] m_lval = '0;
  logic [15:0] m_hq[$];
  logic [15:0] m_data = '0;
  logic        m_valid = 1'b0;

  // Slot position is a pure function of the cycles elapsed since reset.
  function automatic int model_timer(input int cyc);
    return SLOT_LEN - (cyc % (SLOT_LEN + 1));
  endfunction

  function automatic bit model_mode(input int cyc);
    return bit'((cyc / (SLOT_LEN + 1)) % 2);
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, k);
    end
  endtask

  // Drives one cycle of inputs, advances the model across the edge, then
  // compares all outputs one time unit after the edge.
  task automatic applyStimulus(input logic r, input logic lv, input logic [15:0] ld,
                               input logic hv, input logic [15:0] hd);
    int  t;
    bit  md;
    bit  lpush;
    bit  hpush;
    rst        = r;
    l_in_valid = lv;
    l_in_data  = ld;
    h_in_valid = hv;
    h_in_data  = hd;
    if (r) begin
      k       = 0;
      m_lfull = 0;
      m_hq.delete();
      m_data  = '0;
      m_valid = 1'b0;
    end else begin
      t     = model_timer(k);
      md    = model_mode(k);
      lpush = lv && !m_lfull;
      hpush = hv && (m_hq.size() != DEPTH);
      m_data  = '0;
      m_valid = 1'b0;
      if (t != 0 && !md && m_lfull) begin
        m_data  = m_lval;
        m_valid = 1'b1;
        m_lfull = 0;
      end else if (t != 0 && md && m_hq.size() != 0) begin
        m_data  = m_hq.pop_front();
        m_valid = 1'b1;
      end
      if (lpush) begin
        m_lfull = 1;
        m_lval  = ld;
      end
      if (hpush) m_hq.push_back(hd);
      k++;
    end
    @(posedge clk);
    #1;
    checkOutput("timer", timer, 16'(model_timer(k)));
    checkOutput("mode", {15'b0, mode}, {15'b0, model_mode(k)});
    checkOutput("data", data, m_data);
    checkOutput("data_valid", {15'b0, data_valid}, {15'b0, m_valid});
    checkOutput("l_in_ready", {15'b0, l_in_ready}, {15'b0, !m_lfull});
    checkOutput("h_in_ready", {15'b0, h_in_ready}, {15'b0, m_hq.size() != DEPTH});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  logic [17:0] trace_a [64];
  logic        rl_v [64];
  logic [15:0] rl_d [64];

  initial begin
    rst        = 1'b1;
    l_in_valid = 1'b0;
    l_in_data  = '0;
    h_in_valid = 1'b0;
    h_in_data  = '0;
    #2;

    // Reset values, then an idle schedule through two slot boundaries.
    doReset();
    doReset();
    checkOutput("reset_timer", timer, 16'd10);
    checkOutput("reset_mode", {15'b0, mode}, 16'd0);
    checkOutput("reset_valid", {15'b0, data_valid}, 16'd0);
    idle(11);
    checkOutput("slot1_mode", {15'b0, mode}, 16'd1);
    checkOutput("slot1_timer", timer, 16'd10);
    idle(11);
    checkOutput("slot2_mode", {15'b0, mode}, 16'd0);

    // L word offered at timer==5 in an L slot.
    idle(5);
    checkOutput("lsend_timer", timer, 16'd5);
    applyStimulus(1'b0, 1'b1, 16'h000F, 1'b0, 16'h0);
    checkOutput("lsend_ready", {15'b0, l_in_ready}, 16'd0);
    idle(1);
    checkOutput("lsend_data", data, 16'h000F);
    idle(1);
    checkOutput("lsend_clear", data, 16'h0000);
    checkOutput("lsend_ready2", {15'b0, l_in_ready}, 16'd1);

    // Three H words pushed in an L slot wait for the H slot.
    doReset();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 16'h00A1);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 16'h00A2);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 16'h00A3);
    idle(9);
    checkOutput("h_first", data, 16'h00A1);
    idle(2);
    checkOutput("h_third", data, 16'h00A3);
    idle(12);

    // Five back-to-back H pushes into a 4-deep queue during an L slot.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 16'h00B0 + 16'(i));
    checkOutput("hfull_ready", {15'b0, h_in_ready}, 16'd0);
    idle(30);

    // Keep the queue fed through a whole H slot so it fills every data cycle.
    doReset();
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 16'h0C00 + 16'(i));
    idle(25);

    // Reset mid H slot with the queue occupied and the L register full.
    doReset();
    idle(13);
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b1, 16'h0D01);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 16'h0D02);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 16'h0D03);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 16'h0D04);
    doReset();
    checkOutput("midrst_ready", {15'b0, h_in_ready}, 16'd1);
    idle(40);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                    1'($urandom_range(0, 3) == 0), 16'($urandom),
                    1'($urandom_range(0, 1)), 16'($urandom));
    end

    // L-visible traces must not change when H traffic is added.
    for (int i = 0; i < 64; i++) begin
      rl_v[i] = 1'($urandom_range(0, 2) == 0);
      rl_d[i] = 16'($urandom);
    end
    doReset();
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b0, rl_v[i], rl_d[i], 1'b0, 16'h0);
      trace_a[i] = {timer, mode, l_in_ready};
    end
    doReset();
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b0, rl_v[i], rl_d[i], 1'($urandom_range(0, 1)), 16'($urandom));
      checks++;
      assert ({timer, mode, l_in_ready} === trace_a[i]) else begin
        errors++;
        $error("[TB] FAIL l_trace observed=%h expected=%h (step %0d)",
               {timer, mode, l_in_ready}, trace_a[i], i);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
